// File: rtl/mfrc522_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mfrc522_pkg
// Description : Shared constants for the MFRC522 init sequencer: register
//               addresses, the SoftReset command code, error codes and the
//               post-reset register initialisation table.
// Revision    : 1.0 - initial release
// ============================================================================
package mfrc522_pkg;

    // MFRC522 register addresses (6-bit register space)
    localparam logic [5:0] c_addr_command     = 6'h01;
    localparam logic [5:0] c_addr_mode        = 6'h11;
    localparam logic [5:0] c_addr_tx_control  = 6'h14;
    localparam logic [5:0] c_addr_tx_ask      = 6'h15;
    localparam logic [5:0] c_addr_t_mode      = 6'h2A;
    localparam logic [5:0] c_addr_t_prescaler = 6'h2B;
    localparam logic [5:0] c_addr_t_reload_h  = 6'h2C;
    localparam logic [5:0] c_addr_t_reload_l  = 6'h2D;
    localparam logic [5:0] c_addr_version     = 6'h37;

    // CommandReg value that triggers a soft reset
    localparam logic [7:0] c_cmd_soft_reset = 8'h0F;

    // CommandReg PowerDown bit: stays set while the soft reset is in progress
    localparam int c_power_down_bit = 4;

    // Sequence result codes
    localparam logic [1:0] c_err_none         = 2'b00;
    localparam logic [1:0] c_err_poll_timeout = 2'b01;
    localparam logic [1:0] c_err_bad_version  = 2'b10;
    localparam logic [1:0] c_err_cmd_timeout  = 2'b11;

    // Number of entries in the initialisation table
    localparam int INIT_LEN = 7;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } reg_wr_t;

    // Initialisation table: timer setup, 100% ASK, CRC preset, antenna on.
    function automatic reg_wr_t init_entry(input logic [2:0] idx);
        reg_wr_t e;
        case (idx)
            3'd0:    e = '{addr: c_addr_t_mode,      data: 8'h8D};
            3'd1:    e = '{addr: c_addr_t_prescaler, data: 8'h3E};
            3'd2:    e = '{addr: c_addr_t_reload_l,  data: 8'h1E};
            3'd3:    e = '{addr: c_addr_t_reload_h,  data: 8'h00};
            3'd4:    e = '{addr: c_addr_tx_ask,      data: 8'h40};
            3'd5:    e = '{addr: c_addr_mode,        data: 8'h3D};
            3'd6:    e = '{addr: c_addr_tx_control,  data: 8'h83};
            default: e = '{addr: 6'h00,              data: 8'h00};
        endcase
        return e;
    endfunction

    // Known MFRC522 / FM17522 silicon versions
    function automatic logic version_ok(input logic [7:0] v);
        return (v == 8'h88) || (v == 8'h91) || (v == 8'h92);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mfrc522_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mfrc522_init_sequencer
// Description : Brings an MFRC522 out of reset: soft reset, poll until the
//               PowerDown bit clears, write the init table, then check the
//               VersionReg. Drives a one-outstanding register-command port.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start               - one-cycle request (ignored unless idle)
//               busy, done, ok      - status; done pulses once per run
//               err_code, version   - result code and last VersionReg value
//               m_cmd_*             - register command handshake/fields/data
// Revision    : 1.0 - initial release
// ============================================================================
module mfrc522_init_sequencer
    import mfrc522_pkg::*;
#(
    parameter int POLL_TIMEOUT_CYCLES = 4096,
    parameter int CMD_TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       ok,
    output logic [1:0] err_code,
    output logic [7:0] version,
    output logic       m_cmd_valid,
    input  logic       m_cmd_ready,
    output logic       m_cmd_is_write,
    output logic [5:0] m_cmd_addr,
    output logic [7:0] m_cmd_wdata,
    input  logic [7:0] m_cmd_rdata,
    input  logic       m_cmd_done
);

    localparam int c_poll_w = $clog2(POLL_TIMEOUT_CYCLES + 1);
    localparam int c_cmd_w  = $clog2(CMD_TIMEOUT_CYCLES + 1);
    localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(POLL_TIMEOUT_CYCLES - 1);
    localparam logic [c_cmd_w-1:0]  c_cmd_last  = c_cmd_w'(CMD_TIMEOUT_CYCLES - 1);
    localparam logic [2:0]          c_idx_last  = 3'(INIT_LEN - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rst_wr  = 3'd1;
    localparam logic [2:0] c_st_poll_rd = 3'd2;
    localparam logic [2:0] c_st_init_wr = 3'd3;
    localparam logic [2:0] c_st_ver_rd  = 3'd4;
    localparam logic [2:0] c_st_finish  = 3'd5;

    localparam logic c_ph_issue = 1'b0;
    localparam logic c_ph_wait  = 1'b1;

    logic [2:0]          r_state;
    logic                r_phase;
    logic [2:0]          r_index;
    logic [c_poll_w-1:0] r_poll_cnt;
    logic [c_cmd_w-1:0]  r_cmd_cnt;

    logic       w_cmd_state;
    logic       w_accept;
    logic       w_done_seen;
    logic       w_cmd_timeout;
    logic       w_poll_timeout;
    logic       w_go_finish;
    logic [1:0] w_fin_err;
    reg_wr_t    w_next_entry;
    reg_wr_t    w_first_entry;

    assign w_cmd_state    = (r_state == c_st_rst_wr) || (r_state == c_st_poll_rd) ||
                            (r_state == c_st_init_wr) || (r_state == c_st_ver_rd);
    assign w_accept       = m_cmd_valid && m_cmd_ready;
    // m_cmd_done only counts while a command is actually outstanding
    assign w_done_seen    = w_cmd_state && (r_phase == c_ph_wait) && m_cmd_done;
    assign w_cmd_timeout  = w_cmd_state && (r_phase == c_ph_wait) && (r_cmd_cnt == c_cmd_last);
    assign w_poll_timeout = (r_state == c_st_poll_rd) && (r_poll_cnt == c_poll_last);
    assign w_next_entry   = init_entry(r_index + 3'd1);
    assign w_first_entry  = init_entry(3'd0);

    // Termination decision. A returning m_cmd_done takes priority over the
    // command timeout; a poll read that still shows PowerDown set when the
    // poll budget runs out ends the run.
    always_comb begin
        w_go_finish = 1'b0;
        w_fin_err   = c_err_none;
        if (w_done_seen) begin
            if ((r_state == c_st_poll_rd) && m_cmd_rdata[c_power_down_bit] && w_poll_timeout) begin
                w_go_finish = 1'b1;
                w_fin_err   = c_err_poll_timeout;
            end else if (r_state == c_st_ver_rd) begin
                w_go_finish = 1'b1;
                w_fin_err   = version_ok(m_cmd_rdata) ? c_err_none : c_err_bad_version;
            end
        end else if (w_poll_timeout) begin
            w_go_finish = 1'b1;
            w_fin_err   = c_err_poll_timeout;
        end else if (w_cmd_timeout) begin
            w_go_finish = 1'b1;
            w_fin_err   = c_err_cmd_timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_phase        <= c_ph_issue;
            r_index        <= '0;
            r_poll_cnt     <= '0;
            r_cmd_cnt      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ok             <= 1'b0;
            err_code       <= c_err_none;
            version        <= 8'h00;
            m_cmd_valid    <= 1'b0;
            m_cmd_is_write <= 1'b0;
            m_cmd_addr     <= 6'h00;
            m_cmd_wdata    <= 8'h00;
        end else begin
            done <= 1'b0;
            if (r_state == c_st_idle) begin
                if (start) begin
                    r_state        <= c_st_rst_wr;
                    r_phase        <= c_ph_issue;
                    busy           <= 1'b1;
                    ok             <= 1'b0;
                    err_code       <= c_err_none;
                    version        <= 8'h00;
                    m_cmd_valid    <= 1'b1;
                    m_cmd_is_write <= 1'b1;
                    m_cmd_addr     <= c_addr_command;
                    m_cmd_wdata    <= c_cmd_soft_reset;
                end
            end else if (r_state == c_st_finish) begin
                r_state <= c_st_idle;
            end else begin
                if (r_state == c_st_poll_rd) begin
                    r_poll_cnt <= r_poll_cnt + 1'b1;
                end
                if (r_phase == c_ph_issue) begin
                    if (w_accept) begin
                        m_cmd_valid <= 1'b0;
                        r_phase     <= c_ph_wait;
                        r_cmd_cnt   <= '0;
                    end
                end else begin
                    r_cmd_cnt <= r_cmd_cnt + 1'b1;
                end

                if (w_done_seen && (r_state == c_st_ver_rd)) begin
                    version <= m_cmd_rdata;
                end

                if (w_go_finish) begin
                    r_state     <= c_st_finish;
                    r_phase     <= c_ph_issue;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    ok          <= (w_fin_err == c_err_none);
                    err_code    <= w_fin_err;
                    m_cmd_valid <= 1'b0;
                end else if (w_done_seen) begin
                    // Every surviving completion issues the next command;
                    // a busy poll simply re-issues the unchanged read.
                    r_phase     <= c_ph_issue;
                    m_cmd_valid <= 1'b1;
                    case (r_state)
                        c_st_rst_wr: begin
                            r_state        <= c_st_poll_rd;
                            r_poll_cnt     <= '0;
                            m_cmd_is_write <= 1'b0;
                            m_cmd_addr     <= c_addr_command;
                            m_cmd_wdata    <= 8'h00;
                        end
                        c_st_poll_rd: begin
                            if (!m_cmd_rdata[c_power_down_bit]) begin
                                r_state        <= c_st_init_wr;
                                r_index        <= 3'd0;
                                m_cmd_is_write <= 1'b1;
                                m_cmd_addr     <= w_first_entry.addr;
                                m_cmd_wdata    <= w_first_entry.data;
                            end
                        end
                        c_st_init_wr: begin
                            if (r_index == c_idx_last) begin
                                r_state        <= c_st_ver_rd;
                                m_cmd_is_write <= 1'b0;
                                m_cmd_addr     <= c_addr_version;
                                m_cmd_wdata    <= 8'h00;
                            end else begin
                                r_index        <= r_index + 3'd1;
                                m_cmd_is_write <= 1'b1;
                                m_cmd_addr     <= w_next_entry.addr;
                                m_cmd_wdata    <= w_next_entry.data;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mfrc522_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mfrc522_init_sequencer
// Description : Scoreboard bench for mfrc522_init_sequencer. Scenarios push
//               expected commands/results; a monitor pops and compares on
//               every accepted command and every done pulse. A behavioural
//               register responder answers the command port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mfrc522_init_sequencer;

    typedef struct packed {
        logic       w;
        logic [5:0] a;
        logic [7:0] d;
    } cmd_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] err;
        logic [7:0] ver;
    } res_t;

    localparam logic [5:0] TBL_A [7] = '{6'h2A, 6'h2B, 6'h2D, 6'h2C, 6'h15, 6'h11, 6'h14};
    localparam logic [7:0] TBL_D [7] = '{8'h8D, 8'h3E, 8'h1E, 8'h00, 8'h40, 8'h3D, 8'h83};

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, ok;
    logic [1:0] err_code;
    logic [7:0] version;
    logic       m_cmd_valid, m_cmd_ready, m_cmd_is_write, m_cmd_done;
    logic [5:0] m_cmd_addr;
    logic [7:0] m_cmd_wdata, m_cmd_rdata;

    mfrc522_init_sequencer #(
        .POLL_TIMEOUT_CYCLES(200),
        .CMD_TIMEOUT_CYCLES (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .ok            (ok),
        .err_code      (err_code),
        .version       (version),
        .m_cmd_valid   (m_cmd_valid),
        .m_cmd_ready   (m_cmd_ready),
        .m_cmd_is_write(m_cmd_is_write),
        .m_cmd_addr    (m_cmd_addr),
        .m_cmd_wdata   (m_cmd_wdata),
        .m_cmd_rdata   (m_cmd_rdata),
        .m_cmd_done    (m_cmd_done)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   accept_cyc = 0;
    int   done_cyc = 0;
    cmd_t exp_cmd_q[$];
    res_t exp_res_q[$];

    // responder configuration
    int         ready_delay = 1;
    int         done_lat = 20;
    logic [7:0] cmd_rd_q[$];
    logic [7:0] cmd_rd_default = 8'h10;
    logic [7:0] ver_val = 8'h92;
    int         hang_tbl = 0;
    int         tbl_writes = 0;
    bit         resp_busy = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- register responder ----------------
    initial begin
        cmd_t cur;
        logic hang;
        logic [7:0] rd;
        m_cmd_ready = 1'b0;
        m_cmd_done  = 1'b0;
        m_cmd_rdata = 8'h00;
        forever begin
            @(negedge clk);
            while (m_cmd_valid && !rst) begin
                resp_busy = 1'b1;
                cur = {m_cmd_is_write, m_cmd_addr, m_cmd_wdata};
                repeat (ready_delay) @(negedge clk);
                ready_delay = 1;
                m_cmd_ready = 1'b1;
                @(negedge clk);
                m_cmd_ready = 1'b0;
                hang = 1'b0;
                if (cur.w && cur.a != 6'h01) begin
                    tbl_writes++;
                    hang = (hang_tbl != 0) && (tbl_writes == hang_tbl);
                end
                rd = 8'h00;
                if (!cur.w && cur.a == 6'h01)
                    rd = (cmd_rd_q.size() > 0) ? cmd_rd_q.pop_front() : cmd_rd_default;
                else if (!cur.w && cur.a == 6'h37)
                    rd = ver_val;
                if (!hang) begin
                    repeat (done_lat - 1) @(negedge clk);
                    m_cmd_rdata = rd;
                    m_cmd_done  = 1'b1;
                    @(negedge clk);
                    m_cmd_done  = 1'b0;
                    m_cmd_rdata = 8'h00;
                end
                resp_busy = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit   prev_hold = 1'b0;
        cmd_t prev_cmd = '0;
        cmd_t got;
        cmd_t e;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                got = {m_cmd_is_write, m_cmd_addr, m_cmd_wdata};
                if (prev_hold) begin
                    check("cmd_hold_valid", {31'd0, m_cmd_valid}, 32'd1);
                    check("cmd_hold_fields", {17'd0, got}, {17'd0, prev_cmd});
                end
                prev_hold = m_cmd_valid && !m_cmd_ready;
                prev_cmd  = got;
                if (m_cmd_valid && m_cmd_ready) begin
                    accept_cyc = cyc;
                    if (exp_cmd_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_cmd: got %h expected none", got);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        check("cmd", {17'd0, got}, {17'd0, e});
                    end
                end
                if (done) begin
                    done_cyc = cyc;
                    done_cnt++;
                    if (exp_res_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_done: got ok=%0d err=%0d expected no done", ok, err_code);
                    end else begin
                        r = exp_res_q.pop_front();
                        check("result", {21'd0, ok, err_code, version}, {21'd0, r});
                        check("busy_at_done", {31'd0, busy}, 32'd0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_cmd(input logic w, input logic [5:0] a, input logic [7:0] d);
        exp_cmd_q.push_back({w, a, d});
    endtask

    task automatic push_prefix(input int n_polls);
        push_cmd(1'b1, 6'h01, 8'h0F);
        for (int i = 0; i < n_polls; i++) push_cmd(1'b0, 6'h01, 8'h00);
    endtask

    task automatic push_table(input int n);
        for (int i = 0; i < n; i++) push_cmd(1'b1, TBL_A[i], TBL_D[i]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        tbl_writes = 0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (done_cnt == d0) begin
            n_total++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_resp_idle();
        int k = 0;
        while (resp_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("responder_idle", {31'd0, resp_busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int d0;
        int k;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ok", {31'd0, ok}, 32'd0);
        check("rst_err", {30'd0, err_code}, 32'd0);
        check("rst_version", {24'd0, version}, 32'd0);
        check("rst_valid", {31'd0, m_cmd_valid}, 32'd0);
        check("rst_fields", {17'd0, m_cmd_is_write, m_cmd_addr, m_cmd_wdata}, 32'd0);
        rst = 1'b0;

        // Full pass: two busy polls (PowerDown bit 4 set), then clear.
        cmd_rd_q = '{8'h10, 8'h10, 8'h00};
        ver_val  = 8'h92;
        push_prefix(3);
        push_table(7);
        push_cmd(1'b0, 6'h37, 8'h00);
        exp_res_q.push_back({1'b1, 2'b00, 8'h92});
        pulse_start();
        wait_done("full", 2000);
        check("full_cmds_drained", exp_cmd_q.size(), 0);
        repeat (5) @(negedge clk);
        check("full_ok_hold", {23'd0, ok, version}, {23'd0, 1'b1, 8'h92});
        wait_resp_idle();

        // Poll timeout: 32-cycle read period; reads accepted at poll-relative
        // cycles 2,34,..,194, timeout at 200 -> seven reads, no table write.
        cmd_rd_q.delete();
        cmd_rd_default = 8'h10;
        done_lat = 30;
        push_prefix(7);
        exp_res_q.push_back({1'b0, 2'b01, 8'h00});
        pulse_start();
        wait_done("poll_to", 2000);
        check("poll_to_cmds_drained", exp_cmd_q.size(), 0);
        wait_resp_idle();
        done_lat = 20;

        // Unknown version value
        cmd_rd_q = '{8'h00};
        ver_val  = 8'h12;
        push_prefix(1);
        push_table(7);
        push_cmd(1'b0, 6'h37, 8'h00);
        exp_res_q.push_back({1'b0, 2'b10, 8'h12});
        pulse_start();
        wait_done("bad_ver", 2000);
        wait_resp_idle();

        // Third table write never completes
        cmd_rd_q = '{8'h00};
        hang_tbl = 3;
        push_prefix(1);
        push_table(3);
        exp_res_q.push_back({1'b0, 2'b11, 8'h00});
        pulse_start();
        wait_done("cmd_to", 2000);
        check("cmd_to_latency", done_cyc - accept_cyc - 1, 64);
        hang_tbl = 0;
        wait_resp_idle();

        // Ready held low 10 cycles on the first command; start while busy
        cmd_rd_q    = '{8'h00};
        ver_val     = 8'h88;
        ready_delay = 10;
        push_prefix(1);
        push_table(7);
        push_cmd(1'b0, 6'h37, 8'h00);
        exp_res_q.push_back({1'b1, 2'b00, 8'h88});
        pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_ignored_start", {31'd0, busy}, 32'd1);
        wait_done("stall", 2000);
        wait_resp_idle();

        // Reset while table write index 3 is outstanding
        cmd_rd_q = '{8'h00};
        push_prefix(1);
        push_table(4);
        pulse_start();
        k = 0;
        while (exp_cmd_q.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_reached", exp_cmd_q.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_status", {27'd0, busy, done, ok, err_code}, 32'd0);
        check("mid_rst_version", {24'd0, version}, 32'd0);
        check("mid_rst_cmd", {16'd0, m_cmd_valid, m_cmd_is_write, m_cmd_addr, m_cmd_wdata}, 32'd0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        check("no_done_after_rst", done_cnt, d0);
        wait_resp_idle();

        cmd_rd_q = '{8'h00};
        ver_val  = 8'h91;
        push_prefix(1);
        push_table(7);
        push_cmd(1'b0, 6'h37, 8'h00);
        exp_res_q.push_back({1'b1, 2'b00, 8'h91});
        pulse_start();
        wait_done("rerun", 2000);
        check("rerun_cmds_drained", exp_cmd_q.size(), 0);
        wait_resp_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
        $fatal(1);
    end

endmodule
`default_nettype wire
